// File: rtl/freeplay_voice_engine.sv
// rtl/freeplay_voice_engine.sv - polyphonic free-play voice allocator with octave register and LED map
// Optional macro FREEPLAY_SUSTAIN_EN: a voice whose key is still held pauses its countdown until release.
module freeplay_voice_engine #(
  parameter int NOTE_KEYS  = 7,
  parameter int VOICES     = 4,
  parameter int LEN_BITS   = 2,
  parameter int BASE_TICKS = 4,
  parameter int OCT_W      = 2,
  parameter int OCT_MIN    = 0,
  parameter int OCT_MAX    = 3,
  parameter int OCT_RESET  = 1,
  localparam int IDX_W     = (NOTE_KEYS > 1) ? $clog2(NOTE_KEYS) : 1,
  localparam int CNT_W     = $clog2((BASE_TICKS << ((1 << LEN_BITS) - 1)) + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      tick,
  input  logic                      oct_up,
  input  logic                      oct_down,
  input  logic [NOTE_KEYS-1:0]      note_key,
  input  logic [LEN_BITS-1:0]       length_sel,
  output logic [VOICES-1:0]         voice_active,
  output logic [VOICES*IDX_W-1:0]   voice_note,
  output logic [VOICES*OCT_W-1:0]   voice_oct,
  output logic [OCT_W-1:0]          octave,
  output logic [NOTE_KEYS-1:0]      led,
  output logic                      steal
);

  localparam int VIDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;

  logic [NOTE_KEYS-1:0] key_hist, pend, pend_n, rise, svc_mask, led_n;
  logic                 up_hist, dn_hist, up_rise, dn_rise;
  logic [IDX_W-1:0]     v_note [VOICES];
  logic [IDX_W-1:0]     note_n [VOICES];
  logic [OCT_W-1:0]     v_oct  [VOICES];
  logic [OCT_W-1:0]     oct_n  [VOICES];
  logic [CNT_W-1:0]     v_cnt  [VOICES];
  logic [CNT_W-1:0]     cnt_n  [VOICES];
  logic [VOICES-1:0]    v_act, act_n, hold;
  logic [VIDX_W-1:0]    rr, rr_n, target, hit_idx, free_idx;
  logic                 hit_found, free_found, svc_found, svc_valid, steal_n;
  logic [IDX_W-1:0]     svc_key;
  logic [CNT_W-1:0]     load_val;
  logic [OCT_W-1:0]     octave_n;

  // Pick the lowest pending key, then choose retrigger, free slot or round-robin victim.
  always_comb begin
    svc_found = 1'b0;
    svc_key   = '0;
    for (int k = 0; k < NOTE_KEYS; k++) begin
      if (pend[k] && !svc_found) begin
        svc_found = 1'b1;
        svc_key   = IDX_W'(k);
      end
    end
    svc_valid  = en && svc_found;
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int v = 0; v < VOICES; v++) begin
      if (v_act[v] && v_note[v] == svc_key && v_oct[v] == octave && !hit_found) begin
        hit_found = 1'b1;
        hit_idx   = VIDX_W'(v);
      end
      if (!v_act[v] && !free_found) begin
        free_found = 1'b1;
        free_idx   = VIDX_W'(v);
      end
    end
    target   = hit_found ? hit_idx : (free_found ? free_idx : rr);
    steal_n  = svc_valid && !hit_found && !free_found;
    rr_n     = rr;
    if (steal_n)
      rr_n = (rr == VIDX_W'(VOICES - 1)) ? '0 : rr + 1'b1;
    svc_mask = svc_valid ? (NOTE_KEYS'(1) << svc_key) : '0;
    rise     = note_key & ~key_hist;
    pend_n   = en ? (((pend & ~svc_mask) | rise) & note_key) : '0;
    load_val = CNT_W'(BASE_TICKS) << length_sel;
  end

  always_comb begin
    hold = '0;
`ifdef FREEPLAY_SUSTAIN_EN
    for (int v = 0; v < VOICES; v++)
      for (int k = 0; k < NOTE_KEYS; k++)
        if (v_note[v] == IDX_W'(k) && note_key[k])
          hold[v] = 1'b1;
`endif
  end

  // A voice loaded this cycle overrides any tick decrement so it starts with the full count.
  always_comb begin
    act_n = v_act;
    for (int v = 0; v < VOICES; v++) begin
      cnt_n[v]  = v_cnt[v];
      note_n[v] = v_note[v];
      oct_n[v]  = v_oct[v];
      if (tick && v_act[v] && v_cnt[v] != '0 && !hold[v]) begin
        cnt_n[v] = v_cnt[v] - CNT_W'(1);
        if (v_cnt[v] == CNT_W'(1))
          act_n[v] = 1'b0;
      end
      if (svc_valid && target == VIDX_W'(v)) begin
        act_n[v]  = 1'b1;
        cnt_n[v]  = load_val;
        note_n[v] = svc_key;
        oct_n[v]  = octave;
      end
      if (!en) begin
        act_n[v] = 1'b0;
        cnt_n[v] = '0;
      end
    end
  end

  always_comb begin
    led_n = '0;
    for (int k = 0; k < NOTE_KEYS; k++)
      for (int v = 0; v < VOICES; v++)
        if (v_act[v] && v_note[v] == IDX_W'(k))
          led_n[k] = 1'b1;
    if (!en)
      led_n = '0;
  end

  always_comb begin
    up_rise  = oct_up & ~up_hist;
    dn_rise  = oct_down & ~dn_hist;
    octave_n = octave;
    if (up_rise && !dn_rise && octave < OCT_W'(OCT_MAX))
      octave_n = octave + 1'b1;
    else if (dn_rise && !up_rise && octave > OCT_W'(OCT_MIN))
      octave_n = octave - 1'b1;
  end

  // History regs reset high so keys held through reset never register as presses.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_hist <= '1;
      up_hist  <= 1'b1;
      dn_hist  <= 1'b1;
      pend     <= '0;
      v_act    <= '0;
      rr       <= '0;
      steal    <= 1'b0;
      led      <= '0;
      octave   <= OCT_W'(OCT_RESET);
      for (int v = 0; v < VOICES; v++) begin
        v_note[v] <= '0;
        v_oct[v]  <= '0;
        v_cnt[v]  <= '0;
      end
    end else begin
      key_hist <= note_key;
      up_hist  <= oct_up;
      dn_hist  <= oct_down;
      pend     <= pend_n;
      v_act    <= act_n;
      rr       <= rr_n;
      steal    <= steal_n;
      led      <= led_n;
      octave   <= octave_n;
      for (int v = 0; v < VOICES; v++) begin
        v_note[v] <= note_n[v];
        v_oct[v]  <= oct_n[v];
        v_cnt[v]  <= cnt_n[v];
      end
    end
  end

  assign voice_active = v_act;

  always_comb begin
    voice_note = '0;
    voice_oct  = '0;
    for (int v = 0; v < VOICES; v++) begin
      voice_note[v*IDX_W +: IDX_W] = v_note[v];
      voice_oct[v*OCT_W +: OCT_W]  = v_oct[v];
    end
  end

endmodule

// File: tb/tb_freeplay_voice_engine.sv
// tb/tb_freeplay_voice_engine.sv - directed and randomized checks of freeplay_voice_engine against a reference model
module tb_freeplay_voice_engine;
  localparam int NK = 7;
  localparam int NV = 4;
  localparam int IW = 3;
  localparam int OW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          tick = 1'b0;
  logic          oct_up = 1'b0;
  logic          oct_down = 1'b0;
  logic [NK-1:0] note_key = '0;
  logic [1:0]    length_sel = '0;
  logic [NV-1:0]    voice_active;
  logic [NV*IW-1:0] voice_note;
  logic [NV*OW-1:0] voice_oct;
  logic [OW-1:0]    octave;
  logic [NK-1:0]    led;
  logic             steal;

  int n_vec = 0;
  int n_err = 0;

  freeplay_voice_engine dut (
    .clk(clk), .rst(rst), .en(en), .tick(tick), .oct_up(oct_up), .oct_down(oct_down),
    .note_key(note_key), .length_sel(length_sel), .voice_active(voice_active),
    .voice_note(voice_note), .voice_oct(voice_oct), .octave(octave), .led(led), .steal(steal)
  );

  always #5 clk = ~clk;

  // Reference model: voices as records with a remaining-tick count.
  bit          m_act [NV];
  int          m_note [NV];
  int          m_oct [NV];
  int          m_left [NV];
  bit [NK-1:0] m_pend, m_keys_prev, m_led;
  bit          m_up_prev, m_dn_prev, m_steal;
  int          m_octave, m_rr;

  function automatic void model_update();
    bit          was_act [NV];
    bit [NK-1:0] rise, served;
    bit          up, dn, held;
    int          key, tgt;
    if (rst) begin
      for (int v = 0; v < NV; v++) begin
        m_act[v] = 0; m_note[v] = 0; m_oct[v] = 0; m_left[v] = 0;
      end
      m_pend = '0; m_keys_prev = '1; m_up_prev = 1; m_dn_prev = 1;
      m_octave = 1; m_rr = 0; m_steal = 0; m_led = '0;
      return;
    end
    m_led = '0;
    for (int v = 0; v < NV; v++) begin
      was_act[v] = m_act[v];
      if (en && m_act[v]) m_led[m_note[v]] = 1'b1;
    end
    rise = note_key & ~m_keys_prev;
    m_steal = 0;
    served = '0;
    for (int v = 0; v < NV; v++) begin
      held = 0;
`ifdef FREEPLAY_SUSTAIN_EN
      held = note_key[m_note[v]];
`endif
      if (tick && m_act[v] && m_left[v] > 0 && !held) begin
        m_left[v]--;
        if (m_left[v] == 0) m_act[v] = 0;
      end
    end
    if (en && m_pend != 0) begin
      key = 0;
      while (!m_pend[key]) key++;
      served[key] = 1'b1;
      tgt = -1;
      for (int v = 0; v < NV && tgt < 0; v++)
        if (was_act[v] && m_note[v] == key && m_oct[v] == m_octave) tgt = v;
      for (int v = 0; v < NV && tgt < 0; v++)
        if (!was_act[v]) tgt = v;
      if (tgt < 0) begin
        tgt = m_rr;
        m_steal = 1;
        m_rr = (m_rr + 1) % NV;
      end
      m_act[tgt] = 1; m_note[tgt] = key; m_oct[tgt] = m_octave;
      m_left[tgt] = 4 << length_sel;
    end
    m_pend = en ? (((m_pend & ~served) | rise) & note_key) : '0;
    m_keys_prev = note_key;
    up = oct_up && !m_up_prev;
    dn = oct_down && !m_dn_prev;
    if (up && !dn && m_octave < 3) m_octave++;
    else if (dn && !up && m_octave > 0) m_octave--;
    m_up_prev = oct_up;
    m_dn_prev = oct_down;
    if (!en)
      for (int v = 0; v < NV; v++) begin
        m_act[v] = 0; m_left[v] = 0;
      end
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clear_voices();
    en = 0; note_key = '0; tick = 0;
    step();
    en = 1;
    step();
  endtask

  task automatic test_reset();
    rst = 1; en = 0; note_key = 7'h01;
    step(); step();
    n_vec += 6;
    if (voice_active !== 4'h0) begin n_err++; $display("FAIL reset_active got %0h want 0", voice_active); end
    if (led !== 7'h00) begin n_err++; $display("FAIL reset_led got %0h want 0", led); end
    if (steal !== 1'b0) begin n_err++; $display("FAIL reset_steal got %0b want 0", steal); end
    if (octave !== 2'd1) begin n_err++; $display("FAIL reset_octave got %0d want 1", octave); end
    if (voice_note !== '0) begin n_err++; $display("FAIL reset_note got %0h want 0", voice_note); end
    if (voice_oct !== '0) begin n_err++; $display("FAIL reset_oct got %0h want 0", voice_oct); end
    rst = 0; en = 1;
    step(); step(); step();
    n_vec += 2;
    if (voice_active !== 4'h0) begin n_err++; $display("FAIL held_through_reset got %0h want 0", voice_active); end
    if (led !== 7'h00) begin n_err++; $display("FAIL held_through_reset_led got %0h want 0", led); end
    note_key = '0;
    step();
  endtask

  task automatic test_single();
    clear_voices();
    length_sel = 0; note_key = 7'h04;
    step();
    n_vec++;
    if (voice_active !== 4'h0) begin n_err++; $display("FAIL single_latency got %0h want 0", voice_active); end
    step();
    n_vec += 4;
    if (voice_active !== 4'h1) begin n_err++; $display("FAIL single_active got %0h want 1", voice_active); end
    if (voice_note[2:0] !== 3'd2) begin n_err++; $display("FAIL single_note got %0d want 2", voice_note[2:0]); end
    if (voice_oct[1:0] !== 2'd1) begin n_err++; $display("FAIL single_oct got %0d want 1", voice_oct[1:0]); end
    if (led !== 7'h00) begin n_err++; $display("FAIL single_led_lag got %0h want 0", led); end
    note_key = '0;
    step();
    n_vec++;
    if (led !== 7'h04) begin n_err++; $display("FAIL single_led got %0h want 04", led); end
    for (int t = 1; t <= 4; t++) begin
      tick = 1; step(); tick = 0;
      n_vec++;
      if (voice_active[0] !== (t < 4)) begin
        n_err++; $display("FAIL countdown_tick%0d got %0b want %0b", t, voice_active[0], t < 4);
      end
      step();
    end
    n_vec++;
    if (led !== 7'h00) begin n_err++; $display("FAIL single_led_off got %0h want 0", led); end
  endtask

  task automatic test_same_cycle();
    logic [3:0] exp_act [3];
    int         exp_key [3];
    exp_act = '{4'h1, 4'h3, 4'h7};
    exp_key = '{0, 3, 5};
    clear_voices();
    note_key = 7'b0101001;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec += 2;
      if (voice_active !== exp_act[i]) begin
        n_err++; $display("FAIL same_cycle_active%0d got %0h want %0h", i, voice_active, exp_act[i]);
      end
      if (voice_note[i*IW +: IW] !== IW'(exp_key[i])) begin
        n_err++; $display("FAIL same_cycle_note%0d got %0d want %0d", i, voice_note[i*IW +: IW], exp_key[i]);
      end
    end
  endtask

  task automatic test_steal();
    clear_voices();
    length_sel = 3; note_key = 7'h0F;
    repeat (5) step();
    n_vec += 2;
    if (voice_active !== 4'hF) begin n_err++; $display("FAIL steal_fill got %0h want F", voice_active); end
    if (steal !== 1'b0) begin n_err++; $display("FAIL steal_early got %0b want 0", steal); end
    note_key = 7'h1F;
    step(); step();
    n_vec += 2;
    if (steal !== 1'b1) begin n_err++; $display("FAIL steal_pulse5 got %0b want 1", steal); end
    if (voice_note[2:0] !== 3'd4) begin n_err++; $display("FAIL steal_v0_note got %0d want 4", voice_note[2:0]); end
    step();
    n_vec++;
    if (steal !== 1'b0) begin n_err++; $display("FAIL steal_one_cycle got %0b want 0", steal); end
    note_key = 7'h3F;
    step(); step();
    n_vec += 2;
    if (steal !== 1'b1) begin n_err++; $display("FAIL steal_pulse6 got %0b want 1", steal); end
    if (voice_note[5:3] !== 3'd5) begin n_err++; $display("FAIL steal_v1_note got %0d want 5", voice_note[5:3]); end
    note_key = '0;
    step();
  endtask

  task automatic test_octave();
    int exp_oct [4];
    exp_oct = '{2, 3, 3, 3};
    for (int i = 0; i < 4; i++) begin
      oct_up = 1; step();
      n_vec++;
      if (octave !== OW'(exp_oct[i])) begin
        n_err++; $display("FAIL octave_up%0d got %0d want %0d", i, octave, exp_oct[i]);
      end
      oct_up = 0; step();
    end
    oct_up = 1; oct_down = 1; step();
    n_vec++;
    if (octave !== 2'd3) begin n_err++; $display("FAIL octave_both got %0d want 3", octave); end
    oct_up = 0; oct_down = 0; step();
    oct_down = 1; step();
    n_vec++;
    if (octave !== 2'd2) begin n_err++; $display("FAIL octave_down got %0d want 2", octave); end
    oct_down = 0; step();
  endtask

  task automatic test_en_low();
    clear_voices();
    note_key = 7'h40;
    step(); step();
    n_vec++;
    if (voice_active !== 4'h1) begin n_err++; $display("FAIL en_low_setup got %0h want 1", voice_active); end
    en = 0; oct_up = 1;
    step();
    n_vec += 3;
    if (voice_active !== 4'h0) begin n_err++; $display("FAIL en_low_active got %0h want 0", voice_active); end
    if (led !== 7'h00) begin n_err++; $display("FAIL en_low_led got %0h want 0", led); end
    if (octave !== 2'd3) begin n_err++; $display("FAIL en_low_octave got %0d want 3", octave); end
    oct_up = 0; note_key = '0; en = 1;
    step();
  endtask

`ifdef FREEPLAY_SUSTAIN_EN
  task automatic test_sustain();
    clear_voices();
    length_sel = 1; note_key = 7'h02;
    step(); step();
    for (int t = 0; t < 10; t++) begin
      tick = 1; step(); tick = 0; step();
    end
    n_vec++;
    if (voice_active !== 4'h1) begin n_err++; $display("FAIL sustain_hold got %0h want 1", voice_active); end
    note_key = '0;
    for (int t = 1; t <= 8; t++) begin
      tick = 1; step(); tick = 0;
      n_vec++;
      if (voice_active[0] !== (t < 8)) begin
        n_err++; $display("FAIL sustain_release_tick%0d got %0b want %0b", t, voice_active[0], t < 8);
      end
      step();
    end
  endtask
`endif

  task automatic test_random();
    logic [NV-1:0] exp_act;
    rst = 1; step(); rst = 0; en = 1;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      en = ($urandom_range(0, 19) != 0);
      tick = ($urandom_range(0, 3) == 0);
      length_sel = 2'($urandom_range(0, 3));
      for (int k = 0; k < NK; k++)
        if ($urandom_range(0, 7) == 0) note_key[k] = ~note_key[k];
      if ($urandom_range(0, 5) == 0) oct_up = ~oct_up;
      if ($urandom_range(0, 5) == 0) oct_down = ~oct_down;
      step();
      for (int v = 0; v < NV; v++) exp_act[v] = m_act[v];
      n_vec += 4;
      if (voice_active !== exp_act) begin n_err++; $display("FAIL rand_active c%0d got %0h want %0h", c, voice_active, exp_act); end
      if (octave !== OW'(m_octave)) begin n_err++; $display("FAIL rand_octave c%0d got %0d want %0d", c, octave, m_octave); end
      if (led !== m_led) begin n_err++; $display("FAIL rand_led c%0d got %0h want %0h", c, led, m_led); end
      if (steal !== m_steal) begin n_err++; $display("FAIL rand_steal c%0d got %0b want %0b", c, steal, m_steal); end
      for (int v = 0; v < NV; v++) begin
        if (m_act[v]) begin
          n_vec += 2;
          if (voice_note[v*IW +: IW] !== IW'(m_note[v])) begin
            n_err++; $display("FAIL rand_note c%0d v%0d got %0d want %0d", c, v, voice_note[v*IW +: IW], m_note[v]);
          end
          if (voice_oct[v*OW +: OW] !== OW'(m_oct[v])) begin
            n_err++; $display("FAIL rand_oct c%0d v%0d got %0d want %0d", c, v, voice_oct[v*OW +: OW], m_oct[v]);
          end
        end
      end
    end
    rst = 0; tick = 0; oct_up = 0; oct_down = 0; note_key = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_same_cycle();
    test_steal();
    test_octave();
    test_en_low();
`ifdef FREEPLAY_SUSTAIN_EN
    test_sustain();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
